sys_bus_arbiter: RTL and testbench
==================================

// Module: sys_bus_arbiter
// PURPOSE
//  Shares the single data-RAM slave port between the EX stage (master 0:
//  loads/stores) and instruction fetch (master 1: read-only). It grants one
//  transaction at a time, sequences request/ack to the slave, and returns
//  read data. While a master's access is outstanding, it raises that
//  master's hold, which feeds hold_flag_ex / the IF stall.
// PARAMETERS
//  STARVE_MAX  4    consecutive IF losses before IF is forced to win one grant
//  TIMEOUT     255  cycles in BUSY without s_ack before the access is aborted
// PORTS
//  clk         in   1   clock
//  rst_n       in   1   reset, synchronous, active-low
//  m0_req      in   1   EX access request (ram_request_o)
//  m0_we       in   1   EX write enable
//  m0_w_op     in   2   EX write width op, forwarded to slave
//  m0_addr     in   32  EX byte address
//  m0_wdata    in   32  EX store data
//  m0_rdata    out  32  EX load data, valid in m0's RESP cycle
//  m0_hold     out  1   EX stall: access requested but not yet completed
//  m1_req      in   1   IF fetch request
//  m1_addr     in   32  IF fetch address
//  m1_rdata    out  32  fetched word, valid in m1's RESP cycle
//  m1_hold     out  1   IF stall
//  s_req       out  1   slave request, high for the whole BUSY state
//  s_we        out  1   slave write enable (latched from granted master)
//  s_w_op      out  2   slave write op (latched)
//  s_addr      out  32  slave address (latched)
//  s_wdata     out  32  slave write data (latched)
//  s_rdata     in   32  slave read data, sampled on s_ack
//  s_ack       in   1   slave completion strobe
//  bus_err     out  1   one-cycle pulse on timeout abort
// BEHAVIOUR
//  - Reset: state=IDLE, grant=none, starve_cnt=0, tmo_cnt=0. All outputs 0;
//    rdata regs 0. Reset mid-transaction drops it; no ack is honoured after.
//  - FSM IDLE -> BUSY -> RESP -> IDLE.
//    IDLE: if any req, arbitrate; latch we/w_op/addr/wdata of the winner
//      (m1: we=0, w_op=0, wdata=0); go BUSY. With no req, stay IDLE.
//    BUSY: s_req=1 with latched fields. s_ack: capture s_rdata into the
//      winner's rdata reg (stores capture as well; value is don't-care) and
//      go RESP. tmo_cnt counts BUSY cycles; at TIMEOUT with no ack:
//      rdata reg<=0, bus_err=1 for that cycle, go RESP.
//    RESP: one cycle; winner's hold=0; grant cleared; go IDLE.
//  - Arbitration: m0 has fixed priority. Exception: starve_cnt==STARVE_MAX
//    and m1_req -> m1 wins. starve_cnt++ (saturating at STARVE_MAX) when m1
//    loses with m1_req high; cleared when m1 wins or m1_req is low in IDLE.
//  - Hold: mX_hold = mX_req && !(state==RESP && grant==X), combinational.
//    Minimum access takes 3 cycles (IDLE, BUSY with same-cycle ack, RESP),
//    so hold is high 2 cycles. The losing master stays held through the
//    winner's whole transaction.
//  - Masters keep req and fields stable until hold drops; later field
//    changes do not affect a latched access. A req that drops while BUSY
//    does not cancel the access (a store must complete). The rdata of a
//    completed access is held until that master's next completion.
//  - s_ack outside BUSY is ignored. Back-to-back: in the cycle after RESP,
//    IDLE re-arbitrates, so each access has 1 idle bubble (accepted cost).
//  - tmo_cnt is 8 bits (clog2(TIMEOUT+1)); it clears on entry to BUSY.
// TESTING
//  1 m0 load addr 0x100, slave acks in 1st BUSY cycle with 0xDEADBEEF ->
//    m0_hold high 2 cycles, m0_rdata=0xDEADBEEF in RESP, s_we=0.
//  2 m0 and m1 both req in IDLE -> m0 granted first (s_addr=m0_addr);
//    m1_hold stays high until m1's own RESP, 3 cycles after m0's RESP.
//  3 m0_req held continuously, m1_req high -> after 4 m0 grants m1 wins the
//    5th arbitration; starve_cnt then reads 0.
//  4 Slave never acks -> s_req high 255 cycles, bus_err pulse, rdata=0,
//    hold drops in RESP, FSM back in IDLE.
//  5 m0 store (we=1, w_op=2, wdata=0x1234) with 3-cycle ack delay ->
//    s_* stable for all BUSY cycles even if m0_addr toggles.
//  6 rst_n low during BUSY, then s_ack -> IDLE, no rdata update, holds
//    follow req only.

Source files
------------

// File: rtl/sys_bus_arbiter.sv
// sys_bus_arbiter: shares the data-RAM slave port between EX (m0, fixed priority) and IF (m1, anti-starvation), with timeout abort
module sys_bus_arbiter #(
  parameter int STARVE_MAX = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        m0_req,
  input  logic        m0_we,
  input  logic [1:0]  m0_w_op,
  input  logic [31:0] m0_addr,
  input  logic [31:0] m0_wdata,
  output logic [31:0] m0_rdata,
  output logic        m0_hold,
  input  logic        m1_req,
  input  logic [31:0] m1_addr,
  output logic [31:0] m1_rdata,
  output logic        m1_hold,
  output logic        s_req,
  output logic        s_we,
  output logic [1:0]  s_w_op,
  output logic [31:0] s_addr,
  output logic [31:0] s_wdata,
  input  logic [31:0] s_rdata,
  input  logic        s_ack,
  output logic        bus_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam int SW = $clog2(STARVE_MAX + 1);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t state, state_nx;
  logic [1:0] grant;
  logic [SW-1:0] starve_cnt;
  logic [TW-1:0] tmo_cnt;
  logic pick_m1, tmo;
  assign pick_m1 = m1_req && (!m0_req || starve_cnt == SW'(STARVE_MAX));
  assign tmo = tmo_cnt == TW'(TIMEOUT - 1);
  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else state <= state_nx;
  end
  always_comb begin
    state_nx = state == IDLE ? ((m0_req || m1_req) ? BUSY : IDLE) :
               state == BUSY ? ((s_ack || tmo) ? RESP : BUSY) : IDLE;
  end
  always_comb begin
    s_req = state == BUSY;
    bus_err = state == BUSY && !s_ack && tmo;
    m0_hold = m0_req && !(state == RESP && grant[0]);
    m1_hold = m1_req && !(state == RESP && grant[1]);
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      grant <= '0;
      starve_cnt <= '0;
      tmo_cnt <= '0;
      s_we <= 1'b0;
      s_w_op <= '0;
      s_addr <= '0;
      s_wdata <= '0;
      m0_rdata <= '0;
      m1_rdata <= '0;
    end else begin
      if (state == IDLE) begin
        starve_cnt <= (!m1_req || pick_m1) ? '0 :
                      (starve_cnt == SW'(STARVE_MAX)) ? starve_cnt : starve_cnt + 1'b1;
        if (m0_req || m1_req) begin
          grant <= pick_m1 ? 2'b10 : 2'b01;
          s_we <= !pick_m1 && m0_we;
          s_w_op <= pick_m1 ? 2'b00 : m0_w_op;
          s_addr <= pick_m1 ? m1_addr : m0_addr;
          s_wdata <= pick_m1 ? '0 : m0_wdata;
          tmo_cnt <= '0;
        end
      end
      if (state == BUSY) begin
        tmo_cnt <= tmo_cnt + 1'b1;
        if (s_ack || tmo) begin
          if (grant[0]) m0_rdata <= s_ack ? s_rdata : '0;
          if (grant[1]) m1_rdata <= s_ack ? s_rdata : '0;
        end
      end
      if (state == RESP) grant <= '0;
    end
  end
endmodule

// File: tb/tb_sys_bus_arbiter.sv
// tb_sys_bus_arbiter: scoreboard bench for sys_bus_arbiter with a behavioural slave
module tb_sys_bus_arbiter;
  localparam logic [31:0] K = 32'hA5A5_0000;
  logic clk = 1'b0;
  logic rst_n, m0_req, m0_we, m1_req, s_req, s_we, s_ack, bus_err, m0_hold, m1_hold;
  logic [1:0] m0_w_op, s_w_op;
  logic [31:0] m0_addr, m0_wdata, m0_rdata, m1_addr, m1_rdata, s_addr, s_wdata, s_rdata;
  logic slv_ack = 1'b0, force_ack;
  int ack_delay, busy_cnt = 0;
  int checks = 0, errors = 0;
  typedef struct {bit m; bit chk; logic [31:0] d;} exp_t;
  exp_t q[$];

  sys_bus_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .m0_req(m0_req), .m0_we(m0_we), .m0_w_op(m0_w_op), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_rdata(m0_rdata), .m0_hold(m0_hold),
    .m1_req(m1_req), .m1_addr(m1_addr), .m1_rdata(m1_rdata), .m1_hold(m1_hold),
    .s_req(s_req), .s_we(s_we), .s_w_op(s_w_op), .s_addr(s_addr), .s_wdata(s_wdata),
    .s_rdata(s_rdata), .s_ack(s_ack), .bus_err(bus_err)
  );

  always #5 clk = ~clk;

  assign s_rdata = s_addr == 32'h100 ? 32'hDEADBEEF : s_addr ^ K;
  assign s_ack = slv_ack | force_ack;

  always @(posedge clk) begin
    #1;
    if (s_req) begin
      slv_ack = busy_cnt == ack_delay;
      busy_cnt++;
    end else begin
      slv_ack = 1'b0;
      busy_cnt = 0;
    end
  end

  task automatic sb_check();
    exp_t e;
    bit gm;
    logic [31:0] gd;
    if ((m0_req && !m0_hold) || (m1_req && !m1_hold)) begin
      checks++;
      gm = m1_req && !m1_hold;
      gd = gm ? m1_rdata : m0_rdata;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL sb_empty unexpected completion master %0d rdata %h", gm, gd);
      end else begin
        e = q.pop_front();
        if (gm !== e.m || (e.chk && gd !== e.d)) begin
          errors++;
          $display("FAIL sb_resp got master %0d rdata %h want master %0d rdata %h", gm, gd, e.m, e.d);
        end
      end
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #2;
    sb_check();
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m0_req = 0; m0_we = 0; m0_w_op = 0; m0_addr = 0; m0_wdata = 0;
    m1_req = 0; m1_addr = 0; force_ack = 0; ack_delay = 0;
    cyc(); cyc();
    checks++;
    if ({s_req, bus_err, m0_hold, m1_hold, s_we} !== 5'b0 || s_addr !== 0 || s_wdata !== 0 || s_w_op !== 0) begin
      errors++;
      $display("FAIL reset_outs got %b addr %h want 00000 addr 0", {s_req, bus_err, m0_hold, m1_hold, s_we}, s_addr);
    end
    checks++;
    if (m0_rdata !== 0 || m1_rdata !== 0) begin
      errors++;
      $display("FAIL reset_rdata got %h %h want 0 0", m0_rdata, m1_rdata);
    end
    rst_n = 1'b1;
    cyc();
  endtask

  task automatic test_load();
    int n = 0;
    ack_delay = 0;
    q.push_back('{0, 1, 32'hDEADBEEF});
    m0_req = 1; m0_we = 0; m0_addr = 32'h100;
    #1;
    while (m0_hold && n < 10) begin
      n++;
      if (n == 2) begin
        checks++;
        if (s_req !== 1 || s_addr !== 32'h100 || s_we !== 0) begin
          errors++;
          $display("FAIL load_busy got req %b addr %h we %b want 1 00000100 0", s_req, s_addr, s_we);
        end
      end
      cyc();
    end
    checks++;
    if (n != 2) begin errors++; $display("FAIL load_hold_cycles got %0d want 2", n); end
    checks++;
    if (m0_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL load_rdata got %h want deadbeef", m0_rdata); end
    m0_req = 0;
    cyc();
  endtask

  task automatic test_contention();
    int n = 0;
    ack_delay = 0;
    q.push_back('{0, 1, 32'h200 ^ K});
    q.push_back('{1, 1, 32'h300 ^ K});
    m0_req = 1; m0_addr = 32'h200; m1_req = 1; m1_addr = 32'h300;
    cyc();
    checks++;
    if (s_addr !== 32'h200) begin errors++; $display("FAIL contend_first got %h want 00000200", s_addr); end
    cyc();
    checks++;
    if (m0_hold !== 0 || m1_hold !== 1) begin
      errors++;
      $display("FAIL contend_hold got %b%b want 01", m0_hold, m1_hold);
    end
    m0_req = 0;
    while (m1_hold && n < 10) begin cyc(); n++; end
    checks++;
    if (n != 3) begin errors++; $display("FAIL contend_m1_delay got %0d want 3", n); end
    m1_req = 0;
    cyc();
  endtask

  task automatic test_starve();
    bit wins[$];
    logic prev = 0;
    bit want[6] = '{0, 0, 0, 0, 1, 0};
    ack_delay = 0;
    for (int i = 0; i < 6; i++) q.push_back('{want[i], 1, (want[i] ? 32'h500 : 32'h400) ^ K});
    m0_req = 1; m0_addr = 32'h400; m1_req = 1; m1_addr = 32'h500;
    for (int c = 0; c < 60 && wins.size() < 6; c++) begin
      if (s_req && !prev) begin
        wins.push_back(s_addr == 32'h500);
        if (s_addr == 32'h500) begin
          checks++;
          if (dut.starve_cnt !== '0) begin errors++; $display("FAIL starve_clear got %0d want 0", dut.starve_cnt); end
        end
      end
      prev = s_req;
      cyc();
    end
    checks++;
    if (wins.size() != 6) begin errors++; $display("FAIL starve_grants got %0d want 6", wins.size()); end
    for (int i = 0; i < wins.size(); i++) begin
      checks++;
      if (wins[i] != want[i]) begin errors++; $display("FAIL starve_winner_%0d got %0d want %0d", i, wins[i], want[i]); end
    end
    m0_req = 0; m1_req = 0;
    cyc();
  endtask

  task automatic test_timeout();
    int n = 0, errs = 0;
    ack_delay = -1;
    q.push_back('{1, 1, 32'h0});
    m1_req = 1; m1_addr = 32'h600;
    cyc();
    while (s_req && n < 400) begin
      n++;
      if (bus_err) errs++;
      cyc();
    end
    checks++;
    if (n != 255) begin errors++; $display("FAIL tmo_busy_cycles got %0d want 255", n); end
    checks++;
    if (errs != 1) begin errors++; $display("FAIL tmo_bus_err_pulses got %0d want 1", errs); end
    checks++;
    if (m1_hold !== 0 || bus_err !== 0 || m1_rdata !== 0) begin
      errors++;
      $display("FAIL tmo_resp got hold %b err %b rdata %h want 0 0 0", m1_hold, bus_err, m1_rdata);
    end
    m1_req = 0;
    cyc();
    checks++;
    if (s_req !== 0 || m1_hold !== 0) begin errors++; $display("FAIL tmo_idle got req %b hold %b want 0 0", s_req, m1_hold); end
  endtask

  task automatic test_store();
    int n = 0;
    ack_delay = 3;
    q.push_back('{0, 0, 32'h0});
    m0_req = 1; m0_we = 1; m0_w_op = 2; m0_wdata = 32'h1234; m0_addr = 32'h700;
    cyc();
    while (s_req && n < 20) begin
      n++;
      checks++;
      if (s_addr !== 32'h700 || s_we !== 1 || s_w_op !== 2 || s_wdata !== 32'h1234) begin
        errors++;
        $display("FAIL store_fields_%0d got %h %b %0d %h want 00000700 1 2 00001234", n, s_addr, s_we, s_w_op, s_wdata);
      end
      m0_addr = ~m0_addr;
      m0_wdata = ~m0_wdata;
      cyc();
    end
    checks++;
    if (n != 4) begin errors++; $display("FAIL store_busy_cycles got %0d want 4", n); end
    m0_req = 0; m0_we = 0; m0_w_op = 0;
    cyc();
  endtask

  task automatic test_reset_mid();
    ack_delay = -1;
    m0_req = 1; m0_addr = 32'h800;
    cyc();
    checks++;
    if (s_req !== 1) begin errors++; $display("FAIL rstmid_busy got %b want 1", s_req); end
    cyc();
    rst_n = 0; m0_req = 0;
    cyc();
    rst_n = 1; force_ack = 1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      checks++;
      if (s_req !== 0 || m0_rdata !== 0 || m1_rdata !== 0 || m0_hold !== 0 || m1_hold !== 0) begin
        errors++;
        $display("FAIL rstmid_idle_%0d got req %b rdata %h %h holds %b%b want 0 0 0 00", i, s_req, m0_rdata, m1_rdata, m0_hold, m1_hold);
      end
    end
    m1_req = 1;
    #1;
    checks++;
    if (m1_hold !== 1 || m0_hold !== 0) begin errors++; $display("FAIL rstmid_hold_follow got %b%b want 01", m0_hold, m1_hold); end
    m1_req = 0; force_ack = 0;
    cyc();
  endtask

  initial begin
    test_reset();
    test_load();
    test_contention();
    test_starve();
    test_timeout();
    test_store();
    test_reset_mid();
    checks++;
    if (q.size() != 0) begin errors++; $display("FAIL sb_leftover got %0d want 0", q.size()); end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
